tc08_mark_track_writer: RTL and testbench
=========================================

// Module: tc08_mark_track_writer
// PURPOSE
//  Serial mark-track encoder for TC08 DECtape formatting; write-side counterpart of the m228 mark decoder.
//  Emits the complete mark track for one tape pass: reverse end zone, N_BLOCKS blocks, forward end zone.
//  Each mark is a 6-bit code sent MSB first, one bit per timing-track strobe.
//  Sits between the timing-track generator and the mark-track write amplifier.
// PARAMETERS
//  N_BLOCKS    1474  blocks per tape (2702 octal, PDP-8 format)
//  DATA_WORDS  86    data marks (octal 70) per block; one per 18-bit tape word
//  EZ_WORDS    16    marks in each end zone
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous reset, active high
//  start      in   1   one-cycle pulse: begin a format pass (ignored unless idle)
//  abort      in   1   one-cycle pulse: terminate the pass immediately
//  tm_strb    in   1   one-cycle pulse per mark-track bit cell
//  mk_bit     out  1   serial mark bit to the write amplifier
//  mk_wr_en   out  1   write-enable for the mark head
//  mk_code    out  6   code currently being shifted out
//  word_strb  out  1   one-cycle pulse on the cycle the first bit of each mark is loaded
//  blk_num    out  12  current block number, 0-based
//  busy       out  1   pass in progress
//  done       out  1   one-cycle pulse when the pass completes (not on abort)
// BEHAVIOUR
//  Reset: all outputs are 0; FSM is IDLE; bit, slot and block counters are 0.
//   rst overrides start, abort and tm_strb.
//  FSM: IDLE -> ARMED -> EZ_REV -> BLOCK -> EZ_FWD -> IDLE.
//  IDLE: a start pulse moves the FSM to ARMED and sets busy=1 on the next cycle.
//  ARMED: the FSM waits for tm_strb.
//   A tm_strb in the same cycle as start does not emit a bit; emission begins on the next strobe.
//  Marks are loaded on tm_strb when the bit counter is 0.
//   Each tm_strb shifts out one bit; the bit counter counts 0..5 and wraps.
//   mk_bit, mk_wr_en and mk_code update on the cycle after tm_strb (1-cycle latency).
//   mk_bit holds its value between strobes.
//  EZ_REV: EZ_WORDS marks of code 55.
//  BLOCK: the slot sequence is
//   26, 32, 10, 10, 10, 70 x DATA_WORDS, 73, 73, 73, 51, 45, 25 (interblock sync).
//   That is DATA_WORDS+11 marks per block.
//   After slot 25, blk_num increments.
//   When blk_num reaches N_BLOCKS-1 and its 25 mark completes, the FSM goes to EZ_FWD.
//  EZ_FWD: EZ_WORDS marks of code 22.
//   After the last bit of the final 22: done pulses, and busy, mk_wr_en and mk_bit go to 0.
//   blk_num holds its final value until the next start or rst.
//  start is ignored while busy.
//  abort (any state except IDLE) returns the FSM to IDLE on the next cycle.
//   Same cycle as tm_strb: abort wins and no bit is shifted.
//   mk_wr_en, mk_bit and busy go to 0; done is not asserted.
//   All counters clear on the next start.
//  Counters never wrap mid-pass; blk_num width covers N_BLOCKS <= 4095.
//  No strobe-rate requirement, but tm_strb must be spaced at least 2 clocks apart.
// TESTING
//  (params N_BLOCKS=2, DATA_WORDS=3, EZ_WORDS=2 unless noted)
//  1. rst, then start, then 192 strobes spaced 4 clocks -> serial stream decodes to:
//     55,55, 26,32,10,10,10,70,70,70,73,73,73,51,45,25, the same 14 marks again, 22,22.
//     Checks: done pulses once after strobe 192; exactly 32 word_strb pulses.
//  2. start and tm_strb in the same cycle -> no bit on that strobe.
//     First mk_bit=1 (MSB of 55) appears 1 cycle after the next strobe.
//  3. abort during block 1 slot 6 -> next cycle: busy=0, mk_wr_en=0, no done.
//     A new start then replays from 55 with blk_num=0.
//  4. rst asserted mid-pass together with tm_strb -> all outputs 0 next cycle; no bit shifted.
//  5. Extra start pulses while busy, plus strobes 1 clock apart vs 2 apart.
//     Starts are ignored; the stream is identical to scenario 1 at 2-clock spacing.
//  6. Default parameters, full pass -> blk_num ends at 1473.
//     Each block has 97 marks; total strobes = 6*(32 + 1474*97).

Source files
------------

// File: rtl/tc08_mark_track_writer_if.sv
// Mark-track writer bundle: the pass-control strobes come in, and the serial mark stream and pass status go out.
// The master modport drives the control side and the slave modport is the encoder.
interface tc08_mark_track_writer_if;
    logic        i_start;
    logic        i_abort;
    logic        i_tm_strb;
    logic        o_mk_bit;
    logic        o_mk_wr_en;
    logic [5:0]  o_mk_code;
    logic        o_word_strb;
    logic [11:0] o_blk_num;
    logic        o_busy;
    logic        o_done;

    modport master (
        output i_start, i_abort, i_tm_strb,
        input  o_mk_bit, o_mk_wr_en, o_mk_code, o_word_strb, o_blk_num, o_busy, o_done
    );

    modport slave (
        input  i_start, i_abort, i_tm_strb,
        output o_mk_bit, o_mk_wr_en, o_mk_code, o_word_strb, o_blk_num, o_busy, o_done
    );
endinterface

// File: rtl/tc08_mark_track_writer.sv
// TC08 DECtape mark-track encoder: on each timing strobe it shifts out one bit of the 6-bit mark
// code, MSB first, and covers the reverse end zone, N_BLOCKS blocks and the forward end zone.
module tc08_mark_track_writer #(
    parameter int unsigned N_BLOCKS   = 1474,
    parameter int unsigned DATA_WORDS = 86,
    parameter int unsigned EZ_WORDS   = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    tc08_mark_track_writer_if.slave       bus
);
    localparam int unsigned BLK_SLOTS = DATA_WORDS + 11;
    localparam int unsigned SLOT_MAX  = (BLK_SLOTS > EZ_WORDS) ? BLK_SLOTS : EZ_WORDS;
    localparam int unsigned SLOT_W    = $clog2(SLOT_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_EZ_REV, S_BLOCK, S_EZ_FWD} state_t;

    state_t            r_state, w_state_nx, w_phase;
    logic [2:0]        r_bit, w_bit_nx;
    logic [SLOT_W-1:0] r_slot, w_slot_nx, w_tail;
    logic [11:0]       r_blk, w_blk_nx;
    logic              r_mk_bit, w_mk_bit_nx;
    logic              r_wr_en, w_wr_en_nx;
    logic [5:0]        r_code, w_code_nx;
    logic              r_word_strb, w_word_strb_nx;
    logic              r_busy, w_busy_nx;
    logic              r_done, w_done_nx;
    logic [5:0]        w_sel_code, w_cur_code, w_shift;
    logic              w_emit;

    // ARMED emits the first end-zone bit, so it selects codes as EZ_REV does
    always_comb begin
        w_phase    = (r_state == S_ARMED) ? S_EZ_REV : r_state;
        w_tail     = r_slot - SLOT_W'(DATA_WORDS + 5);
        w_sel_code = 6'o22;
        case (w_phase)
            S_EZ_REV: w_sel_code = 6'o55;
            S_BLOCK: begin
                if (r_slot == '0)
                    w_sel_code = 6'o26;
                else if (r_slot == SLOT_W'(1))
                    w_sel_code = 6'o32;
                else if (r_slot < SLOT_W'(5))
                    w_sel_code = 6'o10;
                else if (r_slot < SLOT_W'(DATA_WORDS + 5))
                    w_sel_code = 6'o70;
                else if (w_tail < SLOT_W'(3))
                    w_sel_code = 6'o73;
                else if (w_tail == SLOT_W'(3))
                    w_sel_code = 6'o51;
                else if (w_tail == SLOT_W'(4))
                    w_sel_code = 6'o45;
                else
                    w_sel_code = 6'o25;
            end
            default: w_sel_code = 6'o22;
        endcase
        w_cur_code = (r_bit == 3'd0) ? w_sel_code : r_code;
        w_shift    = w_cur_code << r_bit;
    end

    always_comb begin
        w_state_nx     = r_state;
        w_bit_nx       = r_bit;
        w_slot_nx      = r_slot;
        w_blk_nx       = r_blk;
        w_mk_bit_nx    = r_mk_bit;
        w_wr_en_nx     = r_wr_en;
        w_code_nx      = r_code;
        w_word_strb_nx = 1'b0;
        w_busy_nx      = r_busy;
        w_done_nx      = 1'b0;
        w_emit         = 1'b0;

        if (r_state != S_IDLE && bus.i_abort) begin
            w_state_nx  = S_IDLE;
            w_busy_nx   = 1'b0;
            w_wr_en_nx  = 1'b0;
            w_mk_bit_nx = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        w_state_nx = S_ARMED;
                        w_busy_nx  = 1'b1;
                        w_bit_nx   = '0;
                        w_slot_nx  = '0;
                        w_blk_nx   = '0;
                    end
                end
                S_ARMED: begin
                    if (bus.i_tm_strb) begin
                        w_emit     = 1'b1;
                        w_state_nx = S_EZ_REV;
                    end
                end
                S_EZ_REV, S_BLOCK: w_emit = bus.i_tm_strb;
                S_EZ_FWD: begin
                    // slot == EZ_WORDS means the final 22 has been fully shifted out
                    if (r_slot == SLOT_W'(EZ_WORDS)) begin
                        w_state_nx  = S_IDLE;
                        w_done_nx   = 1'b1;
                        w_busy_nx   = 1'b0;
                        w_wr_en_nx  = 1'b0;
                        w_mk_bit_nx = 1'b0;
                    end else begin
                        w_emit = bus.i_tm_strb;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end

        if (w_emit) begin
            w_code_nx      = w_cur_code;
            w_mk_bit_nx    = w_shift[5];
            w_wr_en_nx     = 1'b1;
            w_word_strb_nx = (r_bit == 3'd0);
            w_bit_nx       = r_bit + 3'd1;
            if (r_bit == 3'd5) begin
                w_bit_nx = '0;
                case (w_phase)
                    S_EZ_REV: begin
                        if (r_slot == SLOT_W'(EZ_WORDS - 1)) begin
                            w_slot_nx  = '0;
                            w_state_nx = S_BLOCK;
                        end else begin
                            w_slot_nx = r_slot + SLOT_W'(1);
                        end
                    end
                    S_BLOCK: begin
                        if (r_slot == SLOT_W'(BLK_SLOTS - 1)) begin
                            w_slot_nx = '0;
                            if (r_blk == 12'(N_BLOCKS - 1))
                                w_state_nx = S_EZ_FWD;
                            else
                                w_blk_nx = r_blk + 12'd1;
                        end else begin
                            w_slot_nx = r_slot + SLOT_W'(1);
                        end
                    end
                    default: w_slot_nx = r_slot + SLOT_W'(1);
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_bit       <= '0;
            r_slot      <= '0;
            r_blk       <= '0;
            r_mk_bit    <= 1'b0;
            r_wr_en     <= 1'b0;
            r_code      <= '0;
            r_word_strb <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_bit       <= w_bit_nx;
            r_slot      <= w_slot_nx;
            r_blk       <= w_blk_nx;
            r_mk_bit    <= w_mk_bit_nx;
            r_wr_en     <= w_wr_en_nx;
            r_code      <= w_code_nx;
            r_word_strb <= w_word_strb_nx;
            r_busy      <= w_busy_nx;
            r_done      <= w_done_nx;
        end
    end

    assign bus.o_mk_bit    = r_mk_bit;
    assign bus.o_mk_wr_en  = r_wr_en;
    assign bus.o_mk_code   = r_code;
    assign bus.o_word_strb = r_word_strb;
    assign bus.o_blk_num   = r_blk;
    assign bus.o_busy      = r_busy;
    assign bus.o_done      = r_done;
endmodule

// File: tb/tb_tc08_mark_track_writer.sv
// Bench for tc08_mark_track_writer: the small-parameter unit covers the pass scenarios, and the
// full-size block geometry is exercised on a short tape.
module tb_tc08_mark_track_writer;
    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic strb  = 1'b0;
    logic sel_b = 1'b0;

    int n_chk  = 0;
    int n_err  = 0;
    int n_done = 0;
    int n_ws   = 0;
    int nb_cur = 0;

    logic [5:0] exp_q[$];
    int         exp_blk[$];

    always #5 clk = ~clk;

    tc08_mark_track_writer_if if_a();
    tc08_mark_track_writer_if if_b();

    tc08_mark_track_writer #(.N_BLOCKS(2), .DATA_WORDS(3), .EZ_WORDS(2)) u_dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if_a.slave)
    );

    tc08_mark_track_writer #(.N_BLOCKS(3), .DATA_WORDS(86), .EZ_WORDS(16)) u_dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if_b.slave)
    );

    assign if_a.i_start   = start & ~sel_b;
    assign if_a.i_abort   = abort & ~sel_b;
    assign if_a.i_tm_strb = strb  & ~sel_b;
    assign if_b.i_start   = start & sel_b;
    assign if_b.i_abort   = abort & sel_b;
    assign if_b.i_tm_strb = strb  & sel_b;

    logic        w_bit, w_wr_en, w_ws, w_busy, w_done;
    logic [5:0]  w_code;
    logic [11:0] w_blk;
    assign w_bit   = sel_b ? if_b.o_mk_bit    : if_a.o_mk_bit;
    assign w_wr_en = sel_b ? if_b.o_mk_wr_en  : if_a.o_mk_wr_en;
    assign w_ws    = sel_b ? if_b.o_word_strb : if_a.o_word_strb;
    assign w_busy  = sel_b ? if_b.o_busy      : if_a.o_busy;
    assign w_done  = sel_b ? if_b.o_done      : if_a.o_done;
    assign w_code  = sel_b ? if_b.o_mk_code   : if_a.o_mk_code;
    assign w_blk   = sel_b ? if_b.o_blk_num   : if_a.o_blk_num;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Every wait goes through here, so each output cycle is sampled exactly once
    task automatic tick();
        @(negedge clk);
        if (w_done) n_done++;
        if (w_ws)   n_ws++;
    endtask

    // Expected mark list for one pass, with the block number each mark belongs to
    function automatic void build(input int nb, input int dw, input int ez);
        logic [5:0] pre[5];
        logic [5:0] post[6];
        pre  = '{6'o26, 6'o32, 6'o10, 6'o10, 6'o10};
        post = '{6'o73, 6'o73, 6'o73, 6'o51, 6'o45, 6'o25};
        exp_q.delete();
        exp_blk.delete();
        nb_cur = nb;
        for (int i = 0; i < ez; i++) begin exp_q.push_back(6'o55); exp_blk.push_back(0); end
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < 5; i++)  begin exp_q.push_back(pre[i]);  exp_blk.push_back(b); end
            for (int i = 0; i < dw; i++) begin exp_q.push_back(6'o70);   exp_blk.push_back(b); end
            for (int i = 0; i < 6; i++)  begin exp_q.push_back(post[i]); exp_blk.push_back(b); end
        end
        for (int i = 0; i < ez; i++) begin exp_q.push_back(6'o22); exp_blk.push_back(nb - 1); end
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_mk_bit"}, w_bit, 0);
        chk({tag, "_wr_en"}, w_wr_en, 0);
        chk({tag, "_code"}, w_code, 0);
        chk({tag, "_word_strb"}, w_ws, 0);
        chk({tag, "_blk"}, w_blk, 0);
        chk({tag, "_busy"}, w_busy, 0);
        chk({tag, "_done"}, w_done, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", w_busy, 1);
        chk("wr_en_armed", w_wr_en, 0);
    endtask

    task automatic strobe_bit(input int gap, input bit extra, output logic b, output logic ws,
                              output logic [5:0] code, output logic [11:0] blk);
        strb  = 1'b1;
        start = extra;
        tick();
        strb  = 1'b0;
        start = 1'b0;
        b    = w_bit;
        ws   = w_ws;
        code = w_code;
        blk  = w_blk;
        chk("wr_en", w_wr_en, 1);
        for (int g = 1; g < gap; g++) begin
            tick();
            chk("hold", w_bit, b);
        end
    endtask

    task automatic run_pass(input int gap_lo, input int gap_hi, input bit extra, input int n_stop);
        int         total, d0, w0;
        logic [5:0] mk, code;
        logic [11:0] blk;
        logic       b, ws;
        total = 6 * exp_q.size();
        d0 = n_done;
        w0 = n_ws;
        mk = '0;
        for (int s = 0; s < n_stop; s++) begin
            int m;
            m = s / 6;
            if (s == total - 1) chk("done_early", n_done - d0, 0);
            strobe_bit(int'($urandom_range(gap_hi, gap_lo)), extra && ($urandom_range(1) == 1),
                       b, ws, code, blk);
            mk = {mk[4:0], b};
            if (s % 6 == 0) begin
                chk("word_strb", ws, 1);
                chk("mk_code", code, exp_q[m]);
                chk("blk_num", blk, exp_blk[m]);
            end else begin
                chk("word_strb_mid", ws, 0);
            end
            if (s % 6 == 5) chk("mark", mk, exp_q[m]);
        end
        if (n_stop == total) begin
            repeat (4) tick();
            chk("done_cnt", n_done - d0, 1);
            chk("word_strb_cnt", n_ws - w0, exp_q.size());
            chk("end_busy", w_busy, 0);
            chk("end_wr_en", w_wr_en, 0);
            chk("end_mk_bit", w_bit, 0);
            chk("end_blk", w_blk, nb_cur - 1);
        end
    endtask

    initial begin
        int d_before;
        build(2, 3, 2);

        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Full pass at 4-clock strobe spacing
        do_start();
        run_pass(4, 4, 1'b0, 6 * exp_q.size());

        // start and tm_strb together: that strobe emits nothing
        start = 1'b1;
        strb  = 1'b1;
        tick();
        start = 1'b0;
        strb  = 1'b0;
        chk("same_cycle_busy", w_busy, 1);
        chk("same_cycle_wr_en", w_wr_en, 0);
        chk("same_cycle_ws", w_ws, 0);
        tick();
        run_pass(2, 5, 1'b0, 6 * exp_q.size());

        // abort in block 1 slot 6, coincident with a strobe
        do_start();
        run_pass(2, 4, 1'b0, 22 * 6 + 2);
        d_before = n_done;
        strb  = 1'b1;
        abort = 1'b1;
        tick();
        strb  = 1'b0;
        abort = 1'b0;
        chk("abort_busy", w_busy, 0);
        chk("abort_wr_en", w_wr_en, 0);
        chk("abort_mk_bit", w_bit, 0);
        chk("abort_done", w_done, 0);
        chk("abort_ws", w_ws, 0);
        repeat (3) tick();
        chk("abort_no_done", n_done - d_before, 0);
        do_start();
        run_pass(2, 3, 1'b0, 6 * exp_q.size());

        // reset mid-pass together with a strobe
        do_start();
        run_pass(2, 3, 1'b0, 50);
        rst  = 1'b1;
        strb = 1'b1;
        tick();
        strb = 1'b0;
        check_all_zero("mid_rst");
        rst = 1'b0;
        tick();
        do_start();
        run_pass(2, 4, 1'b0, 6 * exp_q.size());

        // extra start pulses while busy, tightest strobe spacing
        do_start();
        run_pass(2, 2, 1'b1, 6 * exp_q.size());

        // full block geometry on a short tape
        sel_b = 1'b1;
        tick();
        build(3, 86, 16);
        do_start();
        run_pass(2, 3, 1'b0, 6 * exp_q.size());

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
